ram_port_arbiter: RTL and testbench

//  Owns the single shared SRAM port and hands it between the CPU bus and the diagnostics block.

---
 rtl/ram_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: owns the single SRAM port and hands it between the CPU bus
// and the diagnostics engine. A diagnostics request halts the CPU. The port is
// granted after HALT_SETTLE stalled bus cycles, or after TIMEOUT clocks with no
// bus activity. On release the RAM idles for one cycle before the CPU gets it back.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   CPU_OWN   | CPU drives the RAM, no halt from the arbiter
//   HALT_WAIT | CPU halted, counting stalled bus cycles / timeout
//   DIAG_OWN  | diagnostics owns the RAM port, diag_gnt high
//   RELEASE   | one idle RAM cycle, CPU still halted
module ram_port_arbiter #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 8,
   parameter int HALT_SETTLE = 4,
   parameter int TIMEOUT     = 65535
) (
   input  logic              fpga_clk,
   input  logic              fpga_reset,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_we,
   input  logic              cpu_cs,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              cpu_sync,
   output logic              cpu_halt,
   input  logic              hold_halt,
   input  logic              diag_req,
   output logic              diag_gnt,
   input  logic [ADDR_W-1:0] diag_addr,
   input  logic [DATA_W-1:0] diag_wdata,
   input  logic              diag_we,
   input  logic              diag_cs,
   output logic [DATA_W-1:0] diag_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   output logic              ram_cs,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              timeout_flag
);

   localparam int SET_W = $clog2(HALT_SETTLE + 1);
   localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [SET_W-1:0] SETTLE_MAX = SET_W'(HALT_SETTLE);
   localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      CPU_OWN   = 2'd0,
      HALT_WAIT = 2'd1,
      DIAG_OWN  = 2'd2,
      RELEASE   = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic             halt_fsm, halt_nxt;
   logic             gnt_nxt;
   logic             tflag_nxt;
   logic [SET_W-1:0] settle_cnt;
   logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
   logic             settle_done;

   assign cpu_halt    = halt_fsm | hold_halt;
   assign settle_done = (settle_cnt == SETTLE_MAX);

   // Count stalled bus cycles; any gap in the halt restarts the count.
   always_ff @(posedge fpga_clk or negedge fpga_reset) begin
      if (!fpga_reset) begin
         settle_cnt <= '0;
      end else if (!cpu_halt) begin
         settle_cnt <= '0;
      end else if (cpu_sync && !settle_done) begin
         settle_cnt <= settle_cnt + 1'b1;
      end
   end

   // FSM and grant/halt/timeout registers.
   always_ff @(posedge fpga_clk or negedge fpga_reset) begin
      if (!fpga_reset) begin
         state        <= CPU_OWN;
         halt_fsm     <= 1'b0;
         diag_gnt     <= 1'b0;
         timeout_flag <= 1'b0;
         tmo_cnt      <= '0;
      end else begin
         state        <= state_nxt;
         halt_fsm     <= halt_nxt;
         diag_gnt     <= gnt_nxt;
         timeout_flag <= tflag_nxt;
         tmo_cnt      <= tmo_nxt;
      end
   end

   // Next-state logic. The settle check has priority over the timeout, so a
   // grant on the same cycle as the timeout counts as a normal grant.
   always_comb begin
      state_nxt = state;
      halt_nxt  = halt_fsm;
      gnt_nxt   = diag_gnt;
      tflag_nxt = timeout_flag;
      tmo_nxt   = tmo_cnt;
      case (state)
         CPU_OWN: begin
            if (diag_req) begin
               state_nxt = HALT_WAIT;
               halt_nxt  = 1'b1;
               tmo_nxt   = '0;
            end
         end
         HALT_WAIT: begin
            if (!diag_req) begin
               state_nxt = CPU_OWN;
               halt_nxt  = 1'b0;
            end else if (settle_done) begin
               state_nxt = DIAG_OWN;
               gnt_nxt   = 1'b1;
               tflag_nxt = 1'b0;
            end else if (tmo_cnt == TMO_LAST) begin
               state_nxt = DIAG_OWN;
               gnt_nxt   = 1'b1;
               tflag_nxt = 1'b1;
            end else if (cpu_sync) begin
               tmo_nxt = '0;
            end else begin
               tmo_nxt = tmo_cnt + 1'b1;
            end
         end
         DIAG_OWN: begin
            if (!diag_req) begin
               state_nxt = RELEASE;
               gnt_nxt   = 1'b0;
            end
         end
         RELEASE: begin
            state_nxt = CPU_OWN;
            halt_nxt  = 1'b0;
         end
         default: begin
            state_nxt = CPU_OWN;
            halt_nxt  = 1'b0;
            gnt_nxt   = 1'b0;
         end
      endcase
   end

   // RAM port mux, decoded from the registered state only.
   always_comb begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we;
      ram_cs    = cpu_cs;
      case (state)
         DIAG_OWN: begin
            ram_addr  = diag_addr;
            ram_wdata = diag_wdata;
            ram_we    = diag_we;
            ram_cs    = diag_cs;
         end
         RELEASE: begin
            ram_addr  = diag_addr;
            ram_wdata = diag_wdata;
            ram_we    = 1'b0;
            ram_cs    = 1'b0;
         end
         default: ;
      endcase
   end

   assign cpu_rdata  = ram_rdata;
   assign diag_rdata = diag_gnt ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM. Read data
// expectations go through a queue: they are pushed when a read is driven and
// popped when the read data is sampled.
module tb_ram_port_arbiter;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;

   logic              fpga_clk = 1'b0;
   logic              fpga_reset;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_we, cpu_cs;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_sync, cpu_halt, hold_halt;
   logic              diag_req, diag_gnt;
   logic [ADDR_W-1:0] diag_addr;
   logic [DATA_W-1:0] diag_wdata;
   logic              diag_we, diag_cs;
   logic [DATA_W-1:0] diag_rdata;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_we, ram_cs;
   logic [DATA_W-1:0] ram_rdata;
   logic              timeout_flag;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] sb_q[$];
   int n_assert = 0;
   int n_fail   = 0;

   ram_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HALT_SETTLE(4), .TIMEOUT(16)
   ) dut (
      .fpga_clk(fpga_clk), .fpga_reset(fpga_reset),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_cs(cpu_cs),
      .cpu_rdata(cpu_rdata), .cpu_sync(cpu_sync), .cpu_halt(cpu_halt),
      .hold_halt(hold_halt), .diag_req(diag_req), .diag_gnt(diag_gnt),
      .diag_addr(diag_addr), .diag_wdata(diag_wdata), .diag_we(diag_we),
      .diag_cs(diag_cs), .diag_rdata(diag_rdata),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_cs(ram_cs),
      .ram_rdata(ram_rdata), .timeout_flag(timeout_flag)
   );

   always #5 fpga_clk = ~fpga_clk;

   always @(posedge fpga_clk) begin
      if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
   end
   assign ram_rdata = mem[ram_addr];

   initial begin
      #200000;
      $display("FAIL watchdog: observed simulation still running, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sb_pop_chk(input string tag, input logic [DATA_W-1:0] obs);
      logic [DATA_W-1:0] exp;
      if (sb_q.size() == 0) begin
         exp = 'x;
         chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
      end else begin
         exp = sb_q.pop_front();
         chk(tag, 32'(obs), 32'(exp));
      end
   endtask

   task automatic cyc();
      @(posedge fpga_clk);
      #2;
   endtask

   task automatic sync_pulse();
      cpu_sync = 1'b1;
      cyc();
      cpu_sync = 1'b0;
   endtask

   initial begin
      fpga_reset = 1'b0;
      cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_cs = 1'b0;
      cpu_sync = 1'b0; hold_halt = 1'b0; diag_req = 1'b0;
      diag_addr = '0; diag_wdata = '0; diag_we = 1'b0; diag_cs = 1'b0;
      #12;
      chk("rst_halt", 32'(cpu_halt), 32'd0);
      chk("rst_gnt", 32'(diag_gnt), 32'd0);
      chk("rst_tflag", 32'(timeout_flag), 32'd0);
      chk("rst_diag_rdata", 32'(diag_rdata), 32'd0);
      fpga_reset = 1'b1;
      cyc();

      // 1: CPU write while idle
      cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'hA5;
      #1;
      chk("t1_ram_cs", 32'(ram_cs), 32'd1);
      chk("t1_ram_we", 32'(ram_we), 32'd1);
      chk("t1_ram_addr", 32'(ram_addr), 32'h1234);
      chk("t1_ram_wdata", 32'(ram_wdata), 32'hA5);
      cyc();
      cpu_we = 1'b0;
      sb_q.push_back(8'hA5);
      #1;
      sb_pop_chk("t1_cpu_rd", cpu_rdata);
      chk("t1_gnt", 32'(diag_gnt), 32'd0);
      cpu_cs = 1'b0;

      // 2: request with bus cycles every 8 clocks
      diag_req = 1'b1; diag_cs = 1'b1; diag_we = 1'b1;
      diag_addr = 16'h0000; diag_wdata = 8'h11;
      #1;
      chk("t2_diag_ignored", 32'(ram_cs), 32'd0);
      cyc();
      chk("t2_halt", 32'(cpu_halt), 32'd1);
      chk("t2_gnt_early", 32'(diag_gnt), 32'd0);
      for (int i = 0; i < 4; i++) begin
         repeat (7) cyc();
         sync_pulse();
         chk($sformatf("t2_gnt_sync%0d", i), 32'(diag_gnt), 32'd0);
      end
      cyc();
      chk("t2_gnt", 32'(diag_gnt), 32'd1);
      chk("t2_tflag", 32'(timeout_flag), 32'd0);
      chk("t2_ram_cs", 32'(ram_cs), 32'd1);
      chk("t2_ram_addr", 32'(ram_addr), 32'h0000);
      chk("t2_ram_wdata", 32'(ram_wdata), 32'h11);

      // 3: diagnostics writes then reads 0..3; CPU strobes must be ignored
      for (int i = 0; i < 4; i++) begin
         diag_addr = 16'(i); diag_wdata = 8'(8'h40 + i);
         cyc();
      end
      diag_we = 1'b0;
      cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0002; cpu_wdata = 8'hEE;
      for (int i = 0; i < 4; i++) begin
         diag_addr = 16'(i);
         sb_q.push_back(8'(8'h40 + i));
         #1;
         chk($sformatf("t3_ram_we%0d", i), 32'(ram_we), 32'd0);
         sb_pop_chk($sformatf("t3_rd%0d", i), diag_rdata);
         cyc();
      end
      diag_addr = 16'h0002;
      sb_q.push_back(8'h42);
      #1;
      sb_pop_chk("t3_rd2_again", diag_rdata);
      cpu_we = 1'b0; cpu_addr = 16'h1234;
      diag_req = 1'b0; diag_cs = 1'b1;
      cyc();
      chk("t3_rel_cs", 32'(ram_cs), 32'd0);
      chk("t3_rel_we", 32'(ram_we), 32'd0);
      chk("t3_rel_halt", 32'(cpu_halt), 32'd1);
      chk("t3_rel_gnt", 32'(diag_gnt), 32'd0);
      chk("t3_rel_rdata", 32'(diag_rdata), 32'd0);
      cyc();
      chk("t3_cpu_halt", 32'(cpu_halt), 32'd0);
      chk("t3_cpu_cs", 32'(ram_cs), 32'd1);
      sb_q.push_back(8'hA5);
      sb_pop_chk("t3_cpu_rd", cpu_rdata);
      cpu_cs = 1'b0; diag_cs = 1'b0;

      // 4: hold_halt saturates the settle count, grant comes one cycle after entry
      hold_halt = 1'b1;
      #1;
      chk("t4_hold_halt", 32'(cpu_halt), 32'd1);
      for (int i = 0; i < 10; i++) sync_pulse();
      chk("t4_gnt_idle", 32'(diag_gnt), 32'd0);
      diag_req = 1'b1;
      cyc();
      chk("t4_gnt_1clk", 32'(diag_gnt), 32'd0);
      cyc();
      chk("t4_gnt_2clk", 32'(diag_gnt), 32'd1);
      diag_req = 1'b0;
      cyc();
      cyc();
      chk("t4_halt_held", 32'(cpu_halt), 32'd1);
      chk("t4_gnt_off", 32'(diag_gnt), 32'd0);
      hold_halt = 1'b0;
      #1;
      chk("t4_halt_off", 32'(cpu_halt), 32'd0);
      cyc();

      // 5: no bus cycles, forced grant after 16 clocks in HALT_WAIT
      diag_req = 1'b1;
      cyc();
      repeat (15) cyc();
      chk("t5_gnt_15", 32'(diag_gnt), 32'd0);
      cyc();
      chk("t5_gnt_16", 32'(diag_gnt), 32'd1);
      chk("t5_tflag", 32'(timeout_flag), 32'd1);
      diag_req = 1'b0;
      cyc(); cyc();
      chk("t5_tflag_sticky", 32'(timeout_flag), 32'd1);
      hold_halt = 1'b1;
      for (int i = 0; i < 4; i++) sync_pulse();
      diag_req = 1'b1;
      cyc(); cyc();
      chk("t5_norm_gnt", 32'(diag_gnt), 32'd1);
      chk("t5_tflag_clr", 32'(timeout_flag), 32'd0);
      diag_req = 1'b0; hold_halt = 1'b0;
      cyc(); cyc(); cyc();

      // 6: request abandoned in HALT_WAIT, then reset while granted
      diag_req = 1'b1;
      cyc();
      chk("t6_wait_halt", 32'(cpu_halt), 32'd1);
      diag_req = 1'b0;
      cyc();
      chk("t6_abort_halt", 32'(cpu_halt), 32'd0);
      chk("t6_abort_gnt", 32'(diag_gnt), 32'd0);
      diag_req = 1'b1;
      repeat (17) cyc();
      chk("t6_pre_rst_gnt", 32'(diag_gnt), 32'd1);
      fpga_reset = 1'b0;
      #1;
      chk("t6_rst_gnt", 32'(diag_gnt), 32'd0);
      chk("t6_rst_halt", 32'(cpu_halt), 32'd0);
      chk("t6_rst_tflag", 32'(timeout_flag), 32'd0);
      diag_req = 1'b0; cpu_cs = 1'b1;
      cyc();
      fpga_reset = 1'b1;
      cyc();
      chk("t6_cpu_own", 32'(ram_cs), 32'd1);
      cpu_cs = 1'b0;
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
